bufg_gt_multi: RTL and testbench
================================

# bufg_gt_multi

Parametrised, multi-channel successor to the single-channel GT clock buffer/divider in the xilinx2asic layer. Each of `NCH` channels divides the shared input clock by a run-time value `DIV+1` and gates it. Gating is glitch-free: clocks stop and start only at period boundaries. Odd ratios have a defined duty cycle, and a `SYNC` pulse phase-aligns all running channels. The block sits between the clock source and per-domain clock trees, feeding the standard-cell clock buffers.

## Interface
- `NCH`, default 4: number of independent output channels.
- `DIV_W`, default 4: divide-code width per channel. Ratio N = DIV+1, range 1..2^DIV_W.

- `I`  input  1  source clock. All sequential logic uses posedge `I`, except the bypass gate flop, which uses negedge `I`.
- `CLR_N`  input  1  asynchronous, active-low reset.
- `CE`  input  NCH  per-channel clock enable, synchronous to `I`.
- `DIV`  input  NCH*DIV_W  per-channel divide code. Channel k uses bits [k*DIV_W +: DIV_W].
- `SYNC`  input  1  single-cycle phase-align request, synchronous to `I`.
- `O`  output  NCH  divided/gated clocks.
- `RUN`  output  NCH  channel k is currently running.

## Operation
- Per-channel state:
  - `run` flag.
  - `cnt`, DIV_W bits.
  - `div_q`, the active divide code, DIV_W bits.
  - `o_reg`, the registered divided clock.
  - `g`, the bypass gate; negedge flop.
- Derived values: N = div_q+1 and H = ceil(N/2) = (N+1)>>1, both computed in DIV_W+1 bits with no overflow. A period is H cycles high, then N-H cycles low.
  - Example: N=5 gives HHHLL.
  - Example: N=2 gives HL.
- Channel **stopped** (`run`=0), on posedge:
  - `CE`=1: `run`<=1, `cnt`<=0, `div_q`<=`DIV`, `o_reg`<=(`DIV`!=0).
  - `CE`=0: hold.
- Channel **running, divide mode** (`div_q`!=0), on posedge:
  - `cnt`!=N-1: `cnt`<=`cnt`+1; `o_reg`<=((`cnt`+1)<H).
  - `cnt`==N-1 is the boundary:
    - `CE`=0: `run`<=0, `o_reg`<=0, `cnt` held.
    - Otherwise: `cnt`<=0, `div_q`<=`DIV`, `o_reg`<=(`DIV`!=0).
- Channel **running, bypass mode** (`div_q`==0): every posedge is a boundary.
  - `CE`=0 stops the channel.
  - `div_q`<=`DIV` on every edge.
- `DIV` is sampled only at boundaries or at start. A mid-period change never shortens or stretches the current period.
- `SYNC`=1 at a posedge: every channel with `run`=1 and `CE`=1 takes `cnt`<=0, `div_q`<=`DIV`, `o_reg`<=(`DIV`!=0). `SYNC` overrides the boundary/count logic. A runt period at the `SYNC` edge is permitted.
- Bypass gate, on negedge `I`: `g`<=`run` & (`div_q`==0).
- Output: `O[k]` = (`div_q`==0) ? (`I` & `g`) : `o_reg`. The output passes through the existing clock-buffer cell.
- `RUN[k]` = `run`.

## Timing
- Reset (`CLR_N`=0), asynchronous and immediate: `run`=0, `cnt`=0, `div_q`=0, `o_reg`=0, `g`=0. This gives `O`=0 and `RUN`=0.
- Reset mid-operation truncates the current pulse immediately.
- Start latency: `O` rises at the first posedge sampling `CE`=1. `RUN` rises on the same edge.
  - Bypass exception: the first `O` pulse comes one posedge later, once `g` has been set at the intervening negedge.
- Stop latency: the current period always completes. `O` ends low and `RUN` falls at the boundary edge that samples `CE`=0.
- `CE` toggling mid-period has no effect until the boundary.
- Divide to bypass: the switch happens at a boundary where `o_reg`=0. `O` stays low until the next negedge sets `g`. No glitch.
- Bypass to divide: `o_reg` rises on the edge where `I` rises. No glitch.
- Channels are fully independent, except for `SYNC`.

## Test plan
- Reset: `CLR_N`=0 with `CE`=all-ones → `O`=0, `RUN`=0. Release `CLR_N`, `DIV`=3 → `O[0]` rises at the first posedge and runs HHLL repeating.
- Odd ratio: `DIV`=4, `CE`=1 → `O` runs HHHLL with period 5. `DIV`=1 → HL.
- Glitch-free stop: N=4, drop `CE` when `cnt`=1 → `O` completes H,L,L, then holds 0. `RUN` falls at the `cnt`=3 boundary edge. Re-raise `CE` → `O` high at the next posedge.
- Mid-period `DIV` change 3→1 at `cnt`=1 → the current period stays 4 cycles (HHLL), then HL repeats.
- Bypass: `DIV`=0, `CE`=1 → `O`=`I` from the second posedge onward. Drop `CE` → `O` stops low after the next falling edge.
- `SYNC`: ch0 `DIV`=3, ch1 `DIV`=5, at arbitrary phases. Pulse `SYNC` → both rise on the same edge. Ch2 with `CE`=0 stays stopped. Assert `CLR_N`=0 mid-high → all `O` go to 0 immediately.

Source files
------------

// File: rtl/bufg_gt_multi.sv
// Multi-channel GT clock divider/gate: each channel divides I by DIV+1 and starts, stops,
// and changes ratio only at period boundaries. SYNC restarts all running channels in phase.
module bufg_gt_multi #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIV_W = 4
) (
  input  logic                 I,
  input  logic                 CLR_N,
  input  logic [NCH-1:0]       CE,
  input  logic [NCH*DIV_W-1:0] DIV,
  input  logic                 SYNC,
  output logic [NCH-1:0]       O,
  output logic [NCH-1:0]       RUN
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic             run_q, run_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             o_q, o_d;
    logic             g_q, g_d;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W:0]   n, h, cnt_inc;
    logic             bypass;
    logic             reload;

    assign div_in = DIV[k*DIV_W +: DIV_W];

    always_comb begin
      run_d   = run_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      o_d     = o_q;
      bypass  = (div_q == '0);
      n       = {1'b0, div_q} + (DIV_W+1)'(1);
      h       = (n + (DIV_W+1)'(1)) >> 1;
      cnt_inc = {1'b0, cnt_q} + (DIV_W+1)'(1);
      // SYNC with CE forces the same reload a boundary would perform.
      reload  = (SYNC && CE[k]) || bypass || (cnt_q == div_q);

      if (!run_q) begin
        if (CE[k]) begin
          run_d = 1'b1;
          cnt_d = '0;
          div_d = div_in;
          o_d   = (div_in != '0);
        end
      end else if (reload) begin
        if (!CE[k]) begin
          run_d = 1'b0;
          o_d   = 1'b0;
        end else begin
          cnt_d = '0;
          div_d = div_in;
          o_d   = (div_in != '0);
        end
      end else begin
        cnt_d = cnt_inc[DIV_W-1:0];
        o_d   = (cnt_inc < h);
      end

      g_d = run_q & bypass;
    end

    always_ff @(posedge I or negedge CLR_N) begin
      if (!CLR_N) begin
        run_q <= 1'b0;
        cnt_q <= '0;
        div_q <= '0;
        o_q   <= 1'b0;
      end else begin
        run_q <= run_d;
        cnt_q <= cnt_d;
        div_q <= div_d;
        o_q   <= o_d;
      end
    end

    // Gate changes only while I is low so the bypassed clock never gets a runt.
    always_ff @(negedge I or negedge CLR_N) begin
      if (!CLR_N) begin
        g_q <= 1'b0;
      end else begin
        g_q <= g_d;
      end
    end

    assign O[k]   = bypass ? (I & g_q) : o_q;
    assign RUN[k] = run_q;
  end

endmodule

// File: tb/tb_bufg_gt_multi.sv
// Bench for bufg_gt_multi: period-level reference model compared every half cycle,
// plus directed waveform snippets with hand-derived expectations.
module tb_bufg_gt_multi;
  localparam int NCH = 4;
  localparam int DW  = 4;

  logic               clk;
  logic               clr_n;
  logic [NCH-1:0]     ce;
  logic [NCH*DW-1:0]  div;
  logic               sync;
  logic [NCH-1:0]     o;
  logic [NCH-1:0]     run;

  int errors = 0;
  int checks = 0;

  bufg_gt_multi #(.NCH(NCH), .DIV_W(DW)) dut (
    .I    (clk),
    .CLR_N(clr_n),
    .CE   (ce),
    .DIV  (div),
    .SYNC (sync),
    .O    (o),
    .RUN  (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position inside the current period and the period's ratio.
  bit m_run[NCH];
  int m_pos[NCH];
  int m_n[NCH];
  bit m_g[NCH];

  function automatic int ratio_in(input int k);
    return int'(div[k*DW +: DW]) + 1;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < NCH; k++) begin
        m_run[k] <= 1'b0;
        m_pos[k] <= 0;
        m_n[k]   <= 1;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!m_run[k]) begin
          if (ce[k]) begin
            m_run[k] <= 1'b1;
            m_pos[k] <= 0;
            m_n[k]   <= ratio_in(k);
          end
        end else if ((sync && ce[k]) || m_pos[k] == m_n[k] - 1) begin
          if (!ce[k]) begin
            m_run[k] <= 1'b0;
          end else begin
            m_pos[k] <= 0;
            m_n[k]   <= ratio_in(k);
          end
        end else begin
          m_pos[k] <= m_pos[k] + 1;
        end
      end
    end
  end

  always @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < NCH; k++) m_g[k] <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) m_g[k] <= m_run[k] && (m_n[k] == 1);
    end
  end

  // Divided output: high for the first ceil(N/2) cycles of a running period.
  function automatic logic exp_o(input int k, input bit clk_high);
    if (m_n[k] == 1) return clk_high ? m_g[k] : 1'b0;
    return m_run[k] && (m_pos[k] < (m_n[k] + 1) / 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("model_o_hi[%0d]", k), 32'(o[k]), 32'(exp_o(k, 1'b1)));
      chk($sformatf("model_run[%0d]", k), 32'(run[k]), 32'(m_run[k]));
    end
  end

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < NCH; k++)
      chk($sformatf("model_o_lo[%0d]", k), 32'(o[k]), 32'(exp_o(k, 1'b0)));
  end

  // Shift in O[k] and RUN[k] sampled just after each of the next len posedges.
  task automatic capture(input int k, input int len, output logic [15:0] ov,
                         output logic [15:0] rv);
    ov = '0;
    rv = '0;
    repeat (len) begin
      @(posedge clk);
      #2;
      ov = {ov[14:0], o[k]};
      rv = {rv[14:0], run[k]};
    end
  endtask

  logic [15:0] ov, rv;

  initial begin
    clr_n = 1'b1;
    ce    = '0;
    div   = '0;
    sync  = 1'b0;
    #1 clr_n = 1'b0;
    ce = '1;
    @(posedge clk);
    #2;
    chk("reset_o", 32'(o), 32'h0);
    chk("reset_run", 32'(run), 32'h0);

    // ch0 N=4 from reset release: HHLL repeating.
    @(negedge clk);
    ce = 4'b0001;
    div[0 +: DW] = 4'd3;
    clr_n = 1'b1;
    capture(0, 8, ov, rv);
    chk("div4_o", 32'(ov), 32'h00CC);
    chk("div4_run", 32'(rv), 32'h00FF);

    // ch1 N=5: HHHLL, then N=2 at the boundary: HL.
    @(negedge clk);
    ce[1] = 1'b1;
    div[DW +: DW] = 4'd4;
    capture(1, 10, ov, rv);
    chk("div5_o", 32'(ov), 32'h039C);
    @(negedge clk);
    div[DW +: DW] = 4'd1;
    capture(1, 4, ov, rv);
    chk("div2_o", 32'(ov), 32'h000A);

    // ch2 N=4, CE dropped at cnt=1: period completes, RUN falls at the boundary.
    @(negedge clk);
    ce[2] = 1'b1;
    div[2*DW +: DW] = 4'd3;
    capture(2, 2, ov, rv);
    chk("stop_start_o", 32'(ov), 32'h3);
    @(negedge clk);
    ce[2] = 1'b0;
    capture(2, 4, ov, rv);
    chk("stop_tail_o", 32'(ov), 32'h0);
    chk("stop_tail_run", 32'(rv), 32'hC);
    @(negedge clk);
    ce[2] = 1'b1;
    capture(2, 2, ov, rv);
    chk("restart_o", 32'(ov), 32'h3);

    // DIV 3->1 at cnt=1: current period stays HHLL, then HL.
    @(negedge clk);
    div[2*DW +: DW] = 4'd1;
    capture(2, 6, ov, rv);
    chk("middiv_o", 32'(ov), 32'h0A);

    // ch3 bypass: first pulse one edge late; stop leaves one final pulse.
    @(negedge clk);
    ce[3] = 1'b1;
    div[3*DW +: DW] = 4'd0;
    capture(3, 3, ov, rv);
    chk("bypass_o", 32'(ov), 32'h3);
    chk("bypass_run", 32'(rv), 32'h7);
    @(negedge clk);
    ce[3] = 1'b0;
    capture(3, 2, ov, rv);
    chk("bypass_stop_o", 32'(ov), 32'h2);
    chk("bypass_stop_run", 32'(rv), 32'h0);

    // SYNC: ch0 N=4 and ch1 N=6 at unrelated phases, ch2 stopped.
    @(negedge clk);
    ce[2] = 1'b0;
    div[DW +: DW] = 4'd5;
    repeat (5) @(negedge clk);
    sync = 1'b1;
    @(posedge clk);
    #2;
    chk("sync_o01", 32'(o[1:0]), 32'h3);
    chk("sync_ch2_o", 32'(o[2]), 32'h0);
    chk("sync_ch2_run", 32'(run[2]), 32'h0);
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_o01", 32'(o[1:0]), 32'h3);
    #1 clr_n = 1'b0;
    #1;
    chk("async_rst_o", 32'(o), 32'h0);
    chk("async_rst_run", 32'(run), 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
